// File: rtl/vc_stream_demux4.sv
`default_nettype none
// ============================================================================
// Module   : vc_stream_demux4
// Summary  : Four-way valid/ready stream demultiplexer with a 2-entry FIFO
//            per output lane. Optional zero-latency pass-through for an
//            empty lane is enabled by defining VC_STREAM_DEMUX4_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vc_stream_demux4 #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_val,
    output logic           in_rdy,
    input  logic [1:0]     in_sel,
    input  logic [W-1:0]   in_msg,
    output logic [3:0]     out_val,
    input  logic [3:0]     out_rdy,
    output logic [4*W-1:0] out_msg
);

    localparam int c_NUM_LANES = 4;

    logic [1:0] w_count [c_NUM_LANES];

    // Readiness looks only at the registered count of the selected lane, so
    // a full lane refuses input even in a cycle where it is draining.
    assign in_rdy = (w_count[in_sel] != 2'd2);

    generate
        for (genvar k = 0; k < c_NUM_LANES; k++) begin : g_lane
            logic [1:0]   r_count;
            logic         r_wptr;
            logic         r_rptr;
            logic [W-1:0] r_mem [2];
            logic         w_sel_hit;
            logic         w_bypass;
            logic         w_enq;
            logic         w_deq;

            assign w_sel_hit = in_val && (in_sel == 2'(k));

`ifdef VC_STREAM_DEMUX4_BYPASS_EN
            assign w_bypass = w_sel_hit && (r_count == 2'd0) && out_rdy[k];
`else
            assign w_bypass = 1'b0;
`endif

            // A bypassed message goes straight to the consumer and is never stored.
            assign w_enq = w_sel_hit && in_rdy && !w_bypass;
            assign w_deq = (r_count != 2'd0) && out_rdy[k];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_count <= 2'd0;
                    r_wptr  <= 1'b0;
                    r_rptr  <= 1'b0;
                end else begin
                    if (w_enq) begin
                        r_wptr <= ~r_wptr;
                    end
                    if (w_deq) begin
                        r_rptr <= ~r_rptr;
                    end
                    case ({w_enq, w_deq})
                        2'b10:   r_count <= r_count + 2'd1;
                        2'b01:   r_count <= r_count - 2'd1;
                        default: r_count <= r_count;
                    endcase
                end
            end

            // Payload storage carries no reset; validity is tracked by r_count.
            always_ff @(posedge clk) begin
                if (w_enq) begin
                    r_mem[r_wptr] <= in_msg;
                end
            end

            assign w_count[k]        = r_count;
            assign out_val[k]        = (r_count != 2'd0) || w_bypass;
            assign out_msg[k*W +: W] = w_bypass ? in_msg : r_mem[r_rptr];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vc_stream_demux4.sv
`timescale 1ns/1ps
// Directed self-checking bench for vc_stream_demux4 (default build, no bypass).
module tb_vc_stream_demux4;

    logic         clk;
    logic         reset;
    logic         in_val;
    logic         in_rdy;
    logic [1:0]   in_sel;
    logic [31:0]  in_msg;
    logic [3:0]   out_val;
    logic [3:0]   out_rdy;
    logic [127:0] out_msg;

    int total = 0;
    int bad   = 0;

    vc_stream_demux4 #(.W(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_sel  (in_sel),
        .in_msg  (in_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg)
    );

    initial begin
        clk = 1'b0;
        #20;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] lane(input int k);
        return out_msg[k*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] route_msgs [4];
        logic [31:0] rx [$];
        int          next_val;
        route_msgs[0] = 32'h0a0a0a0a;
        route_msgs[1] = 32'hb0b0b0b0;
        route_msgs[2] = 32'h0c0c0c0c;
        route_msgs[3] = 32'hd0d0d0d0;

        reset   = 1'b0;
        in_val  = 1'b0;
        in_sel  = 2'd0;
        in_msg  = 32'h0;
        out_rdy = 4'hF;

        // ---- Reset with no clock edge: outputs must clear asynchronously
        #3;
        reset = 1'b1;
        #1;
        chk("rst_async_out_val", 32'(out_val), 32'h0);
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            chk($sformatf("rst_async_in_rdy%0d", s), 32'(in_rdy), 32'h1);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("idle_out_val", 32'(out_val), 32'h0);
        chk("idle_in_rdy", 32'(in_rdy), 32'h1);

        // ---- Routing: each payload only on its own lane, one cycle later
        for (int k = 0; k < 4; k++) begin
            in_val = 1'b1;
            in_sel = 2'(k);
            in_msg = route_msgs[k];
            #1;
            chk($sformatf("route_in_rdy%0d", k), 32'(in_rdy), 32'h1);
            chk($sformatf("route_not_early%0d", k), 32'(out_val), 32'h0);
            tick();
            in_val = 1'b0;
            chk($sformatf("route_out_val%0d", k), 32'(out_val), 32'(4'b0001 << k));
            chk($sformatf("route_msg%0d", k), lane(k), route_msgs[k]);
            tick();
            chk($sformatf("route_drained%0d", k), 32'(out_val), 32'h0);
        end

        // ---- Full lane 2 and isolation of lane 0
        out_rdy = 4'b1011;
        for (int i = 0; i < 2; i++) begin
            in_val = 1'b1;
            in_sel = 2'd2;
            in_msg = 32'h2000_0001 + 32'(i);
            #1;
            chk($sformatf("full_accept%0d", i), 32'(in_rdy), 32'h1);
            tick();
        end
        in_msg = 32'h2000_0003;
        #1;
        chk("full_third_rdy", 32'(in_rdy), 32'h0);
        tick();
        chk("full_out_val", 32'(out_val), 32'b0100);
        in_sel = 2'd0;
        in_msg = 32'h0000_4444;
        #1;
        chk("iso_lane0_rdy", 32'(in_rdy), 32'h1);
        tick();
        in_val = 1'b0;
        chk("iso_out_val", 32'(out_val), 32'b0101);
        chk("iso_lane0_msg", lane(0), 32'h0000_4444);
        chk("iso_lane2_head", lane(2), 32'h2000_0001);
        tick();
        // full lane draining this cycle must still refuse input
        in_val  = 1'b1;
        in_sel  = 2'd2;
        in_msg  = 32'h2000_0003;
        out_rdy = 4'hF;
        #1;
        chk("full_deq_rdy", 32'(in_rdy), 32'h0);
        tick();
        in_val = 1'b0;
        chk("full_second", lane(2), 32'h2000_0002);
        chk("full_second_val", 32'(out_val), 32'b0100);
        tick();
        chk("full_empty", 32'(out_val), 32'h0);

        // ---- Order and wrap on lane 1 with toggling consumer ready
        next_val = 1;
        rx.delete();
        for (int cyc = 0; cyc < 40 && rx.size() < 8; cyc++) begin
            out_rdy = {2'b11, (cyc % 2 == 0), 1'b1};
            in_val  = (next_val <= 8);
            in_sel  = 2'd1;
            in_msg  = 32'(next_val);
            #1;
            if (out_val[1] && out_rdy[1]) rx.push_back(lane(1));
            if (in_val && in_rdy) next_val++;
            tick();
        end
        in_val  = 1'b0;
        out_rdy = 4'hF;
        chk("order_count", 32'(rx.size()), 32'd8);
        for (int i = 0; i < rx.size(); i++) begin
            chk($sformatf("order_item%0d", i), rx[i], 32'(i + 1));
        end
        tick();
        chk("order_empty", 32'(out_val), 32'h0);

        // ---- Simultaneous enqueue/dequeue on lane 3 at count 1
        out_rdy = 4'b0111;
        in_val  = 1'b1;
        in_sel  = 2'd3;
        in_msg  = 32'h0000_00AA;
        tick();
        in_msg  = 32'h0000_00BB;
        out_rdy = 4'hF;
        #1;
        chk("simul_rdy", 32'(in_rdy), 32'h1);
        chk("simul_head_aa", lane(3), 32'h0000_00AA);
        tick();
        out_rdy = 4'b0111;
        in_msg  = 32'h0000_00CC;
        #1;
        chk("simul_head_bb", lane(3), 32'h0000_00BB);
        chk("simul_count1_rdy", 32'(in_rdy), 32'h1);
        tick();
        in_msg = 32'h0000_00DD;
        #1;
        chk("simul_count2_full", 32'(in_rdy), 32'h0);
        in_val  = 1'b0;
        out_rdy = 4'hF;
        #1;
        chk("simul_drain_bb", lane(3), 32'h0000_00BB);
        tick();
        chk("simul_drain_cc", lane(3), 32'h0000_00CC);
        tick();
        chk("simul_empty", 32'(out_val), 32'h0);

        // ---- Reset mid-operation
        out_rdy = 4'b0000;
        in_val  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_sel = 2'(i / 2);
            in_msg = 32'h7000_0000 + 32'(i);
            tick();
        end
        in_val = 1'b0;
        chk("mid_filled", 32'(out_val), 32'b0011);
        in_val = 1'b1;
        in_sel = 2'd2;
        in_msg = 32'h0000_0099;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_out_val", 32'(out_val), 32'h0);
        chk("mid_rst_in_rdy", 32'(in_rdy), 32'h1);
        tick();
        reset  = 1'b0;
        in_val = 1'b0;
        chk("mid_lost_handshake", 32'(out_val), 32'h0);
        out_rdy = 4'hF;
        in_val  = 1'b1;
        in_sel  = 2'd0;
        in_msg  = 32'h0000_0055;
        tick();
        in_val = 1'b0;
        chk("mid_resume_val", 32'(out_val), 32'b0001);
        chk("mid_resume_msg", lane(0), 32'h0000_0055);
        tick();
        chk("mid_resume_empty", 32'(out_val), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
